usbf_desc_seq: RTL and testbench
================================

// Module: usbf_desc_seq
// PURPOSE
//  Descriptor read sequencer for the endpoint-0 control path.
//  - On a GET_DESCRIPTOR-type request it reads consecutive 32-bit words from the descriptor ROM (usbf_rom).
//  - It unpacks each word little-endian into a byte stream under a valid/ready handshake.
//  - The stream is truncated to min(descriptor length, wLength) and split into max-packet chunks.
//  - It flags the zero-length packet (ZLP) when one is required.
//  - It sits between the control/setup decoder and the EP0 IN packet builder, and it owns the ROM read port while busy.
// PARAMETERS
//  USBF_SSRAM_HADR  14  ROM address MSB index; the ROM address width is USBF_SSRAM_HADR+1
// PORTS
//  clk_i        in   1    clock
//  rst_i        in   1    asynchronous reset, active-low
//  start_i      in   1    request strobe; sampled only in IDLE
//  base_addr_i  in   HADR+1  ROM word address of descriptor word 0
//  len_src_i    in   1    0: length = byte0 of word0 (bLength); 1: length = {byte3,byte2} of word0 (wTotalLength)
//  wlength_i    in   16   host wLength
//  max_pkt_i    in   7    EP0 max packet size in bytes, 8..64
//  abort_i      in   1    new SETUP or bus reset; cancels the transfer
//  rom_addr_o   out  HADR+1  ROM read address
//  rom_re_o     out  1    ROM read enable (rom we is tied 0 by the instantiating level)
//  rom_data_i   in   32   ROM data_o; valid 1 cycle after rom_re_o
//  byte_o       out  8    stream byte
//  byte_vld_o   out  1    byte_o valid
//  byte_rdy_i   in   1    sink accepts when byte_vld_o && byte_rdy_i
//  pkt_end_o    out  1    qualifies the current byte as the last byte of its packet
//  zlp_o        out  1    1-cycle pulse: sink must send a zero-length packet
//  busy_o       out  1    high from start acceptance until DONE exit
//  done_o       out  1    1-cycle pulse when the transfer completes (not on abort)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; all counters 0.
//  States: IDLE -> HDR_RD -> HDR_WAIT -> (LOAD | DONE); LOAD -> STREAM; STREAM -> (LOAD | DONE); DONE -> IDLE.
//  - IDLE: on start_i, latch inputs, raise busy_o, go to HDR_RD.
//  - HDR_RD: rom_re_o=1 with rom_addr_o=base; go to HDR_WAIT.
//  - HDR_WAIT:
//    - Capture word0 into word_q.
//    - desc_len is 8-bit zero-extended (len_src=0) or 16-bit (len_src=1).
//    - xfer_len = min(desc_len, wlength), 16-bit unsigned compare.
//    - xfer_len==0 -> DONE, with zlp_o=1 that cycle.
//    - Otherwise set byte index 0 and go to STREAM.
//  - STREAM:
//    - byte_vld_o=1; byte_o=word_q[8*idx+7 -:8].
//    - On accept: sent_cnt++, pkt_cnt++, idx++.
//    - pkt_end_o=1 when pkt_cnt==max_pkt_i-1 or sent_cnt==xfer_len-1.
//    - On a pkt_end accept, pkt_cnt clears to 0.
//    - If the accepted byte is the last of the transfer -> DONE.
//    - Else if idx==3 -> LOAD, with rom_re_o=1 and rom_addr_o=addr_q+1 that same cycle.
//  - LOAD: capture rom_data_i into word_q, addr_q++, idx=0, byte_vld_o=0; go to STREAM. This gives 1 bubble per word.
//  - DONE:
//    - done_o=1.
//    - zlp_o=1 same cycle iff xfer_len!=0, xfer_len%max_pkt==0 and xfer_len<wlength.
//    - busy_o drops next cycle; go to IDLE.
//  - abort_i in any non-IDLE state: next cycle IDLE; all outputs 0; no done_o, no zlp_o. Any in-flight ROM read is discarded.
//  - abort_i and start_i together in IDLE: abort wins, start is ignored.
//  - start_i outside IDLE is ignored.
//  - byte_rdy_i low: hold byte_o, byte_vld_o and pkt_end_o stable.
//  - Throughput: at most 4 bytes per 5 cycles. Header latency: start to first byte_vld_o is 3 cycles.
//  - Address increments wrap modulo 2^(HADR+1).
//  - rom_re_o is never asserted in IDLE or DONE.
// STRUCTURE
//  - Shared package / usbf_defines: state encoding localparams (IDLE, HDR_RD, HDR_WAIT, STREAM, LOAD, DONE) and the LEN_SRC_BLEN/LEN_SRC_WTOT constants.
//  - One natural sub-module: usbf_desc_pktcnt, which holds sent_cnt/pkt_cnt and generates pkt_end and zlp.
//  - Everything else stays flat in usbf_desc_seq.
// TESTING
//  - Device descriptor:
//    - Stimulus: word0=0x01000112, len_src=0, wlength=0x40, max_pkt=64.
//    - Required: 18 bytes streamed 12 01 00 01 ...; pkt_end on byte 18; done_o; no zlp.
//  - Truncation:
//    - Stimulus: same descriptor, wlength=8, max_pkt=8.
//    - Required: 8 bytes, pkt_end on byte 8, done_o, zlp_o=0 (xfer_len==wlength).
//  - Config with ZLP:
//    - Stimulus: len_src=1, word0=0x00200209 (wTotalLength=32), wlength=255, max_pkt=16.
//    - Required: pkt_end on bytes 16 and 32; zlp_o pulse with done_o.
//  - Backpressure:
//    - Stimulus: toggle byte_rdy_i randomly during the 18-byte case.
//    - Required: identical byte sequence; outputs stable while stalled; exactly 5 ROM reads.
//  - Abort:
//    - Stimulus: abort_i after 5 accepted bytes.
//    - Required: IDLE next cycle; byte_vld_o=0, busy_o=0; no done_o.
//    - Then a new start_i runs cleanly from word0.
//  - Zero length:
//    - Stimulus: wlength=0.
//    - Required: one ROM read only, no byte_vld_o, done_o with zlp_o=1.
//  - Reset mid-STREAM: assert rst_i -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/usbf_desc_seq_pkg.sv
// Shared types and constants for the EP0 descriptor read sequencer.
package usbf_desc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_RD   = 3'd1,
        HDR_WAIT = 3'd2,
        STREAM   = 3'd3,
        LOAD     = 3'd4,
        DONE     = 3'd5
    } desc_state_e;

    localparam logic LEN_SRC_BLEN = 1'b0;
    localparam logic LEN_SRC_WTOT = 1'b1;

    function automatic logic [15:0] min16(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/usbf_desc_pktcnt.sv
// Byte and packet counters for the descriptor stream; flags packet ends,
// the final byte and whether the transfer ended on a full packet (ZLP due).
module usbf_desc_pktcnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [15:0] xfer_len_i,
    input  logic [15:0] wlength_i,
    input  logic [6:0]  max_pkt_i,
    input  logic        acc_i,
    output logic        pkt_end_o,
    output logic        last_o,
    output logic        zlp_due_o
);

    logic [15:0] sent_cnt_q;
    logic [6:0]  pkt_cnt_q;
    logic [15:0] xfer_len_q;
    logic        full_q;
    logic        pkt_full;

    assign pkt_full  = (pkt_cnt_q == (max_pkt_i - 7'd1));
    assign last_o    = (sent_cnt_q == (xfer_len_q - 16'd1));
    assign pkt_end_o = pkt_full || last_o;
    // Every packet but the last is full, so "last packet full" == length is a multiple of max_pkt.
    assign zlp_due_o = full_q && (xfer_len_q < wlength_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sent_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            xfer_len_q <= '0;
            full_q     <= 1'b0;
        end else if (clr_i) begin
            sent_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            xfer_len_q <= '0;
            full_q     <= 1'b0;
        end else if (load_i) begin
            sent_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            xfer_len_q <= xfer_len_i;
            full_q     <= 1'b0;
        end else if (acc_i) begin
            sent_cnt_q <= sent_cnt_q + 16'd1;
            pkt_cnt_q  <= pkt_end_o ? 7'd0 : (pkt_cnt_q + 7'd1);
            if (last_o) begin
                full_q <= pkt_full;
            end
        end
    end

endmodule

// File: rtl/usbf_desc_seq.sv
// EP0 descriptor read sequencer: reads descriptor words from ROM and streams
// them as bytes, truncated to wLength and split into max-packet chunks.
//
//   state    | meaning
//   IDLE     | waiting for start_i
//   HDR_RD   | issue ROM read of word 0
//   HDR_WAIT | word 0 on rom_data_i; compute transfer length
//   STREAM   | present bytes of word_q on the handshake
//   LOAD     | capture next ROM word (one bubble per word)
//   DONE     | done_o pulse, optional zlp_o
module usbf_desc_seq
    import usbf_desc_seq_pkg::*;
#(
    parameter int USBF_SSRAM_HADR = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [USBF_SSRAM_HADR:0] base_addr_i,
    input  logic                     len_src_i,
    input  logic [15:0]              wlength_i,
    input  logic [6:0]               max_pkt_i,
    input  logic                     abort_i,
    output logic [USBF_SSRAM_HADR:0] rom_addr_o,
    output logic                     rom_re_o,
    input  logic [31:0]              rom_data_i,
    output logic [7:0]               byte_o,
    output logic                     byte_vld_o,
    input  logic                     byte_rdy_i,
    output logic                     pkt_end_o,
    output logic                     zlp_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int AW = USBF_SSRAM_HADR + 1;

    desc_state_e   state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [31:0]   word_q;
    logic [1:0]    idx_q;
    logic          len_src_q;
    logic [15:0]   wlength_q;
    logic [6:0]    max_pkt_q;

    logic [15:0]   desc_len;
    logic [15:0]   xfer_len_d;
    logic          start_acc;
    logic          hdr_load;
    logic          accept;
    logic          cnt_clr;
    logic          pkt_end;
    logic          last_byte;
    logic          zlp_due;

    assign desc_len   = (len_src_q == LEN_SRC_WTOT) ? rom_data_i[31:16] : {8'h00, rom_data_i[7:0]};
    assign xfer_len_d = min16(desc_len, wlength_q);
    assign cnt_clr    = start_acc || (abort_i && (state_q != IDLE));

    always_comb begin
        state_d    = state_q;
        rom_re_o   = 1'b0;
        rom_addr_o = '0;
        byte_vld_o = 1'b0;
        byte_o     = 8'h00;
        pkt_end_o  = 1'b0;
        zlp_o      = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != IDLE);
        start_acc  = 1'b0;
        hdr_load   = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    start_acc = 1'b1;
                    state_d   = HDR_RD;
                end
            end
            HDR_RD: begin
                rom_re_o   = 1'b1;
                rom_addr_o = addr_q;
                state_d    = HDR_WAIT;
            end
            HDR_WAIT: begin
                hdr_load = 1'b1;
                if (xfer_len_d == 16'd0) begin
                    zlp_o   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                byte_vld_o = 1'b1;
                byte_o     = word_q[{idx_q, 3'b000} +: 8];
                pkt_end_o  = pkt_end;
                if (byte_rdy_i) begin
                    accept = 1'b1;
                    if (last_byte) begin
                        state_d = DONE;
                    end else if (idx_q == 2'd3) begin
                        rom_re_o   = 1'b1;
                        rom_addr_o = addr_q + AW'(1);
                        state_d    = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = STREAM;
            end
            DONE: begin
                done_o  = 1'b1;
                zlp_o   = zlp_due;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort cancels everything this cycle; any ROM data already in flight is ignored.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            rom_re_o   = 1'b0;
            rom_addr_o = '0;
            zlp_o      = 1'b0;
            done_o     = 1'b0;
            hdr_load   = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            word_q    <= '0;
            idx_q     <= '0;
            len_src_q <= 1'b0;
            wlength_q <= '0;
            max_pkt_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                addr_q    <= base_addr_i;
                len_src_q <= len_src_i;
                wlength_q <= wlength_i;
                max_pkt_q <= max_pkt_i;
                idx_q     <= '0;
            end
            if (abort_i && (state_q != IDLE)) begin
                idx_q <= '0;
            end else if (hdr_load) begin
                word_q <= rom_data_i;
                idx_q  <= '0;
            end else if (state_q == LOAD) begin
                word_q <= rom_data_i;
                addr_q <= addr_q + AW'(1);
                idx_q  <= '0;
            end else if (accept) begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    usbf_desc_pktcnt u_pktcnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (cnt_clr),
        .load_i     (hdr_load),
        .xfer_len_i (xfer_len_d),
        .wlength_i  (wlength_q),
        .max_pkt_i  (max_pkt_q),
        .acc_i      (accept),
        .pkt_end_o  (pkt_end),
        .last_o     (last_byte),
        .zlp_due_o  (zlp_due)
    );

endmodule

// File: tb/tb_usbf_desc_seq.sv
// Self-checking bench for usbf_desc_seq: ROM model plus a byte scoreboard.
module tb_usbf_desc_seq;

    localparam int HADR = 14;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            start_i = 1'b0;
    logic [HADR:0]   base_addr_i = '0;
    logic            len_src_i = 1'b0;
    logic [15:0]     wlength_i = '0;
    logic [6:0]      max_pkt_i = 7'd64;
    logic            abort_i = 1'b0;
    logic [HADR:0]   rom_addr_o;
    logic            rom_re_o;
    logic [31:0]     rom_data_i;
    logic [7:0]      byte_o;
    logic            byte_vld_o;
    logic            byte_rdy_i = 1'b0;
    logic            pkt_end_o;
    logic            zlp_o;
    logic            busy_o;
    logic            done_o;

    int checks = 0;
    int failures = 0;

    logic [8:0] sb[$];
    logic [7:0] rom_bytes [0:255];

    int rd_cnt, done_cnt, zlp_cnt, zlp_done_cnt, vld_cnt, acc_cnt, first_vld;
    bit finished;

    usbf_desc_seq #(.USBF_SSRAM_HADR(HADR)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .len_src_i   (len_src_i),
        .wlength_i   (wlength_i),
        .max_pkt_i   (max_pkt_i),
        .abort_i     (abort_i),
        .rom_addr_o  (rom_addr_o),
        .rom_re_o    (rom_re_o),
        .rom_data_i  (rom_data_i),
        .byte_o      (byte_o),
        .byte_vld_o  (byte_vld_o),
        .byte_rdy_i  (byte_rdy_i),
        .pkt_end_o   (pkt_end_o),
        .zlp_o       (zlp_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (rom_re_o) begin
            rom_data_i <= {rom_bytes[{rom_addr_o[5:0], 2'b11}], rom_bytes[{rom_addr_o[5:0], 2'b10}],
                           rom_bytes[{rom_addr_o[5:0], 2'b01}], rom_bytes[{rom_addr_o[5:0], 2'b00}]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drives one request, scoreboards the byte stream and tallies ROM reads, done and zlp pulses.
    task automatic run_stream(input int base, input logic lsrc, input logic [15:0] wlen,
                              input logic [6:0] mp, input bit rnd, input int abort_after);
        int dlen, xfer;
        bit stalled, stopped;
        logic [7:0] pb;
        logic pe;
        logic [8:0] e;
        rd_cnt = 0; done_cnt = 0; zlp_cnt = 0; zlp_done_cnt = 0;
        vld_cnt = 0; acc_cnt = 0; first_vld = -1; finished = 0; stopped = 0;
        dlen = lsrc ? int'({rom_bytes[4*base+3], rom_bytes[4*base+2]}) : int'(rom_bytes[4*base]);
        xfer = (dlen < int'(wlen)) ? dlen : int'(wlen);
        for (int i = 0; i < xfer; i++) begin
            e[7:0] = rom_bytes[4*base+i];
            e[8]   = (((i + 1) % int'(mp)) == 0) || (i == xfer - 1);
            sb.push_back(e);
        end
        @(posedge clk_i); #1;
        base_addr_i = (HADR+1)'(base);
        len_src_i   = lsrc;
        wlength_i   = wlen;
        max_pkt_i   = mp;
        start_i     = 1'b1;
        byte_rdy_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        byte_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = 0;
        for (int cyc = 0; cyc < 400 && !finished && !stopped; cyc++) begin
            @(negedge clk_i);
            if (stalled) begin
                checks++;
                if (byte_o !== pb || byte_vld_o !== 1'b1 || pkt_end_o !== pe) begin
                    failures++;
                    $display("FAIL stall_hold: byte=%h vld=%b end=%b required byte=%h vld=1 end=%b",
                             byte_o, byte_vld_o, pkt_end_o, pb, pe);
                end
            end
            stalled = 0;
            if (rom_re_o === 1'b1) rd_cnt++;
            if (done_o === 1'b1) done_cnt++;
            if (zlp_o === 1'b1) zlp_cnt++;
            if (zlp_o === 1'b1 && done_o === 1'b1) zlp_done_cnt++;
            if (byte_vld_o === 1'b1) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                if (byte_rdy_i) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL stream_extra: byte=%h end=%b required no byte", byte_o, pkt_end_o);
                    end else begin
                        e = sb.pop_front();
                        if ({pkt_end_o, byte_o} !== e)  begin
                            failures++;
                            $display("FAIL stream_byte[%0d]: end=%b byte=%h required end=%b byte=%h",
                                     acc_cnt, pkt_end_o, byte_o, e[8], e[7:0]);
                        end
                    end
                    acc_cnt++;
                end else begin
                    stalled = 1;
                    pb = byte_o;
                    pe = pkt_end_o;
                end
            end
            if (done_o === 1'b1) begin
                finished = 1;
            end else if (abort_after >= 0 && acc_cnt == abort_after) begin
                stopped = 1;
            end else begin
                @(posedge clk_i); #1;
                byte_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (!finished && !stopped) begin
            checks++;
            failures++;
            $display("FAIL timeout: transfer did not complete, bytes=%0d required %0d", acc_cnt, xfer);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({rom_re_o, rom_addr_o, byte_o, byte_vld_o, pkt_end_o, zlp_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: re=%b addr=%h byte=%h vld=%b end=%b zlp=%b busy=%b done=%b required all 0",
                     rom_re_o, rom_addr_o, byte_o, byte_vld_o, pkt_end_o, zlp_o, busy_o, done_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b required 0", busy_o); end
    endtask

    task automatic test_device();
        run_stream(0, 1'b0, 16'h0040, 7'd64, 1'b0, -1);
        checks++; if (acc_cnt != 18) begin failures++; $display("FAIL dev_bytes: got %0d required 18", acc_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL dev_done: got %0d required 1", done_cnt); end
        checks++; if (zlp_cnt != 0) begin failures++; $display("FAIL dev_zlp: got %0d required 0", zlp_cnt); end
        checks++; if (rd_cnt != 5) begin failures++; $display("FAIL dev_reads: got %0d required 5", rd_cnt); end
        checks++; if (first_vld != 2) begin failures++; $display("FAIL dev_latency: got %0d required 2", first_vld); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL dev_left: got %0d required 0", sb.size()); end
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL dev_after: busy=%b done=%b required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_truncation();
        run_stream(0, 1'b0, 16'd8, 7'd8, 1'b0, -1);
        checks++; if (acc_cnt != 8) begin failures++; $display("FAIL trunc_bytes: got %0d required 8", acc_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL trunc_done: got %0d required 1", done_cnt); end
        checks++; if (zlp_cnt != 0) begin failures++; $display("FAIL trunc_zlp: got %0d required 0", zlp_cnt); end
        checks++; if (rd_cnt != 2) begin failures++; $display("FAIL trunc_reads: got %0d required 2", rd_cnt); end
    endtask

    task automatic test_config_zlp();
        run_stream(8, 1'b1, 16'd255, 7'd16, 1'b0, -1);
        checks++; if (acc_cnt != 32) begin failures++; $display("FAIL cfg_bytes: got %0d required 32", acc_cnt); end
        checks++; if (zlp_done_cnt != 1) begin failures++; $display("FAIL cfg_zlp_done: got %0d required 1", zlp_done_cnt); end
        checks++; if (zlp_cnt != 1) begin failures++; $display("FAIL cfg_zlp: got %0d required 1", zlp_cnt); end
        checks++; if (rd_cnt != 8) begin failures++; $display("FAIL cfg_reads: got %0d required 8", rd_cnt); end
    endtask

    task automatic test_backpressure();
        run_stream(0, 1'b0, 16'h0040, 7'd64, 1'b1, -1);
        checks++; if (acc_cnt != 18) begin failures++; $display("FAIL bp_bytes: got %0d required 18", acc_cnt); end
        checks++; if (rd_cnt != 5) begin failures++; $display("FAIL bp_reads: got %0d required 5", rd_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done: got %0d required 1", done_cnt); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL bp_left: got %0d required 0", sb.size()); end
    endtask

    task automatic test_abort();
        run_stream(0, 1'b0, 16'h0040, 7'd64, 1'b0, 5);
        checks++; if (acc_cnt != 5) begin failures++; $display("FAIL abort_bytes: got %0d required 5", acc_cnt); end
        @(posedge clk_i); #1;
        abort_i = 1'b1;
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL abort_cycle_done: got %b required 0", done_o); end
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0 || byte_vld_o !== 1'b0 || done_o !== 1'b0 || zlp_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b vld=%b done=%b zlp=%b required 0 0 0 0", busy_o, byte_vld_o, done_o, zlp_o);
        end
        sb.delete();
        run_stream(0, 1'b0, 16'h0040, 7'd64, 1'b0, -1);
        checks++; if (acc_cnt != 18) begin failures++; $display("FAIL abort_rerun_bytes: got %0d required 18", acc_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL abort_rerun_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_abort_start_idle();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if (busy_o !== 1'b0 || rom_re_o !== 1'b0) begin
                failures++;
                $display("FAIL abort_wins: busy=%b re=%b required 0 0", busy_o, rom_re_o);
            end
        end
    endtask

    task automatic test_zero_length();
        run_stream(0, 1'b0, 16'd0, 7'd64, 1'b0, -1);
        checks++; if (rd_cnt != 1) begin failures++; $display("FAIL zero_reads: got %0d required 1", rd_cnt); end
        checks++; if (vld_cnt != 0) begin failures++; $display("FAIL zero_vld: got %0d required 0", vld_cnt); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done: got %0d required 1", done_cnt); end
        checks++; if (zlp_cnt != 1) begin failures++; $display("FAIL zero_zlp: got %0d required 1", zlp_cnt); end
    endtask

    task automatic test_reset_mid_stream();
        bit seen;
        seen = 0;
        @(posedge clk_i); #1;
        base_addr_i = '0; len_src_i = 1'b0; wlength_i = 16'h0040; max_pkt_i = 7'd64;
        start_i = 1'b1; byte_rdy_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (byte_vld_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rstmid_stream: vld never seen, required 1"); end
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({rom_re_o, rom_addr_o, byte_o, byte_vld_o, pkt_end_o, zlp_o, busy_o, done_o} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: re=%b addr=%h byte=%h vld=%b end=%b zlp=%b busy=%b done=%b required all 0",
                     rom_re_o, rom_addr_o, byte_o, byte_vld_o, pkt_end_o, zlp_o, busy_o, done_o);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        sb.delete();
        run_stream(0, 1'b0, 16'h0040, 7'd64, 1'b0, -1);
        checks++; if (acc_cnt != 18) begin failures++; $display("FAIL rstmid_rerun: got %0d required 18", acc_cnt); end
    endtask

    initial begin
        logic [7:0] dev [0:17];
        dev = '{8'h12, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40, 8'h34,
                8'h12, 8'h78, 8'h56, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};
        for (int i = 0; i < 256; i++) rom_bytes[i] = 8'hE0 ^ 8'(i);
        for (int i = 0; i < 18; i++) rom_bytes[i] = dev[i];
        rom_bytes[32] = 8'h09; rom_bytes[33] = 8'h02; rom_bytes[34] = 8'h20; rom_bytes[35] = 8'h00;
        for (int i = 4; i < 32; i++) rom_bytes[32+i] = 8'hA0 + 8'(i);

        test_reset();
        test_device();
        test_truncation();
        test_config_zlp();
        test_backpressure();
        test_abort();
        test_abort_start_idle();
        test_zero_length();
        test_reset_mid_stream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
